// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - RV32I instruction-fetch sequencer with redirect, back-pressure and fault handling
//
// Drives a fetch address into a registered instruction memory, tags each
// returned word with the address it was fetched from, and hands words to
// decode in program order over a valid/ready handshake.
//
// Ports:
//   Clk_Core, Rst_Core_N      core clock, asynchronous active-low reset
//   Program_Count   (out)     registered fetch address to instruct_mem
//   Instruction     (in)      instruct_mem read data for last cycle's address
//   Redirect_Valid  (in)      taken branch/jump: flush and refetch
//   Redirect_Target (in)      redirect byte address
//   Decode_Ready    (in)      decode accepts Fetch_* this cycle
//   Fetch_Valid     (out)     Fetch_Instr/Fetch_PC valid
//   Fetch_Instr     (out)     instruction word
//   Fetch_PC        (out)     address of Fetch_Instr
//   Fetch_Fault     (out)     sticky misaligned/out-of-range fetch fault

module fetch_ctrl #(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                MEM_SIZE = 16384
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    output logic [DWIDTH-1:0] Program_Count,
    input  logic [DWIDTH-1:0] Instruction,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Target,
    input  logic              Decode_Ready,
    output logic              Fetch_Valid,
    output logic [DWIDTH-1:0] Fetch_Instr,
    output logic [DWIDTH-1:0] Fetch_PC,
    output logic              Fetch_Fault
);

    localparam logic [DWIDTH-1:0] MEM_LIMIT = DWIDTH'(MEM_SIZE);
    localparam logic [DWIDTH-1:0] STEP      = DWIDTH'(4);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] tag_q;
    logic              tag_vld;
    logic [DWIDTH-1:0] expect_pc;

    logic              hit;
    logic              room;
    logic              accept;
    logic [DWIDTH-1:0] seq_ne;

    function automatic logic illegal(input logic [DWIDTH-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= MEM_LIMIT);
    endfunction

    // If the address we need is already in flight, fetch one ahead;
    // otherwise (re)issue it so it comes back next cycle.
    function automatic logic [DWIDTH-1:0] next_fetch(input logic [DWIDTH-1:0] cur,
                                                     input logic [DWIDTH-1:0] ne);
        return (cur == ne) ? ne + STEP : ne;
    endfunction

    assign Program_Count = pc_q;

    always_comb begin
        hit    = tag_vld && (tag_q == expect_pc);
        room   = !Fetch_Valid || Decode_Ready;
        accept = (state == RUN) && hit && room && !Redirect_Valid;
        seq_ne = accept ? expect_pc + STEP : expect_pc;
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state       <= RUN;
            pc_q        <= RESET_PC;
            expect_pc   <= RESET_PC;
            tag_q       <= '0;
            tag_vld     <= 1'b0;
            Fetch_Valid <= 1'b0;
            Fetch_Instr <= '0;
            Fetch_PC    <= '0;
            Fetch_Fault <= 1'b0;
        end else begin
            // The memory read is registered, so the word arriving now belongs
            // to the address issued one cycle ago.
            tag_q   <= pc_q;
            tag_vld <= 1'b1;

            if (Redirect_Valid) begin
                // Any handshake this cycle still completes; the output is flushed.
                Fetch_Valid <= 1'b0;
                if (illegal(Redirect_Target)) begin
                    state       <= FAULT;
                    Fetch_Fault <= 1'b1;
                end else begin
                    state       <= RUN;
                    Fetch_Fault <= 1'b0;
                    expect_pc   <= Redirect_Target;
                    pc_q        <= next_fetch(pc_q, Redirect_Target);
                end
            end else begin
                if (accept) begin
                    Fetch_Valid <= 1'b1;
                    Fetch_Instr <= Instruction;
                    Fetch_PC    <= tag_q;
                end else if (Fetch_Valid && Decode_Ready) begin
                    Fetch_Valid <= 1'b0;
                end

                if (state == RUN) begin
                    // Falling off the end of memory freezes the fetch pointers;
                    // whatever is already in the output register still drains.
                    if (illegal(seq_ne)) begin
                        state       <= FAULT;
                        Fetch_Fault <= 1'b1;
                    end else begin
                        expect_pc <= seq_ne;
                        pc_q      <= next_fetch(pc_q, seq_ne);
                    end
                end
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RV32I hart. It drives the `Program_Count` address into `instruct_mem`, whose read is registered and returns `Instruction` one cycle later. It tags each returned word with its address and presents in-order instructions to decode over a valid/ready handshake. It also handles decode back-pressure, branch/jump redirects with flush, and fetch faults.

## Interface
Parameters:
- DWIDTH, 32, address/instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- MEM_SIZE, 16384, instruction memory size in bytes; legal fetch addresses are 0..MEM_SIZE-4

Ports (clock: Clk_Core; reset: Rst_Core_N, asynchronous, active-low):
- Clk_Core  in  1  core clock
- Rst_Core_N  in  1  asynchronous active-low reset
- Program_Count  out  DWIDTH  registered fetch address to instruct_mem
- Instruction  in  DWIDTH  instruct_mem read data = mem[Program_Count of previous cycle]
- Redirect_Valid  in  1  branch/jump taken; flush and refetch
- Redirect_Target  in  DWIDTH  redirect byte address
- Decode_Ready  in  1  decode accepts Fetch_* this cycle
- Fetch_Valid  out  1  Fetch_Instr/Fetch_PC valid
- Fetch_Instr  out  DWIDTH  instruction word
- Fetch_PC  out  DWIDTH  address of Fetch_Instr
- Fetch_Fault  out  1  sticky fetch fault (misaligned or out-of-range PC)

## Operation
- Registers: pc_q (drives Program_Count), tag_q/tag_vld (pc_q of previous cycle; address of the current Instruction), expect_pc (next address to deliver), output register, state ∈ {RUN, FAULT}.
- Reset values: pc_q=RESET_PC, expect_pc=RESET_PC, tag_q=0, tag_vld=0, Fetch_Valid=0, Fetch_Instr=0, Fetch_PC=0, Fetch_Fault=0, state=RUN.
- Every edge: tag_q<=pc_q, tag_vld<=1.
- hit = tag_vld & (tag_q==expect_pc); room = !Fetch_Valid | Decode_Ready; accept = RUN & hit & room & !Redirect_Valid.
- accept: output register loads {Instruction, tag_q} with Fetch_Valid<=1; ne = expect_pc+4.
- No accept and Fetch_Valid & Decode_Ready: Fetch_Valid<=0. Otherwise Fetch_* hold stable.
- Redirect_Valid (priority over everything, any state): Fetch_Valid<=0 (flush); ne=Redirect_Target. If the target is illegal, state<=FAULT and Fetch_Fault<=1; otherwise state<=RUN and Fetch_Fault<=0.
- Else ne = accept ? expect_pc+4 : expect_pc.
- Next address rule (RUN): expect_pc<=ne; pc_q<= (pc_q==ne) ? ne+4 : ne. This runs ahead when the needed address is already in flight, and replays it otherwise.
- Stalled (Fetch_Valid & !Decode_Ready): Program_Count alternates expect_pc, expect_pc+4, ... Non-hit data is discarded.
- Illegal address: bits[1:0]≠0 or ≥ MEM_SIZE (unsigned). If sequential ne is illegal, the block enters FAULT instead of updating; instructions already in the output register still complete their handshake.
- FAULT: pc_q and expect_pc hold; no accepts; Fetch_Fault=1. Exit only via reset or a legal redirect.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously). In-flight data is dropped.

## Timing
- Fetch_Valid first rises at the 2nd rising edge after reset release, with Fetch_PC=RESET_PC.
- Steady state (Decode_Ready=1): one instruction per cycle, Fetch_PC increments by 4 each cycle, no bubbles.
- Redirect sampled at edge e: Program_Count=T after e; Fetch_Valid=0 after e and e+1; Fetch_Valid=1 with Fetch_PC=T after e+2.
- Stall release: first accept occurs 0 or 1 cycle after Decode_Ready rises, depending on replay phase. An instruction is never lost or duplicated.
- Decode_Ready is ignored while Fetch_Valid=0. Redirect in the same cycle as a handshake: the handshake completes (decode consumed) and the output is flushed.

## Test plan
- Reset, RESET_PC=0, mem[i]=i, Decode_Ready=1 -> Fetch_PC = 0,4,8,12 on consecutive cycles from the 2nd edge; Fetch_Instr=0,1,2,3.
- Hold Decode_Ready=0 for 5 cycles while Fetch_PC=8 -> Fetch_Instr/PC stable at 8. On release, next Fetch_PC=12 within ≤2 cycles, with no skip or repeat.
- Redirect_Valid with Target=0x100 while streaming -> Fetch_Valid low for 2 cycles, then Fetch_PC=0x100, 0x104...
- Redirect_Target=0x102 -> Fetch_Fault=1, Fetch_Valid=0, Program_Count frozen. A later redirect to 0x40 -> Fetch_Fault=0, Fetch_PC=0x40 two edges later.
- Sequential run to 0x3FFC with MEM_SIZE=16384 -> 0x3FFC is delivered, then FAULT is entered and Fetch_Fault=1.
- Assert Rst_Core_N low mid-stall -> all outputs 0 and Program_Count=RESET_PC immediately. Release -> restart as in the first scenario.
